// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers: FSM state encoding,
// per-boundary payload widths and control-field bit offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Default payload widths per stage boundary
  localparam int unsigned IF_ID_DATA_W  = 64;  // pc + instruction
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 133; // pc + rs1 + rs2 + imm + rd
  localparam int unsigned ID_EX_CTRL_W  = 12;
  localparam int unsigned EX_MEM_DATA_W = 69;  // alu/jal result + rs2 data + rd
  localparam int unsigned EX_MEM_CTRL_W = 7;
  localparam int unsigned MEM_WB_DATA_W = 37;  // writeback value + rd
  localparam int unsigned MEM_WB_CTRL_W = 1;

  // Control-field bit offsets (EX_MEM layout)
  localparam int unsigned MEM_WRITE       = 0;
  localparam int unsigned MEM_READ        = 1;
  localparam int unsigned FUNC3           = 2;  // 3 bits: [4:2]
  localparam int unsigned FUNC3_W         = 3;
  localparam int unsigned WRITE_ENABLE    = 5;
  localparam int unsigned DATA_MEM_SELECT = 6;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/flush event counters for pipe_stage_reg.
// Only present when PIPE_STAGE_STATS_EN is defined.
`ifdef PIPE_STAGE_STATS_EN
module pipe_stage_stats #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add saturating STALL_CNT/FLUSH_CNT outputs.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 7
`ifdef PIPE_STAGE_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL
`ifdef PIPE_STAGE_STATS_EN
  , output logic [CNT_W-1:0] STALL_CNT
  , output logic [CNT_W-1:0] FLUSH_CNT
`endif
);
  import pipe_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_fire;
  logic              out_fire;
  logic              load_in;
  logic              load_from_skid;
  logic              load_skid;
  logic              clear_ctrl;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = TWO;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath load/clear controls
  always_comb begin
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    clear_ctrl     = 1'b0;
    if (FLUSH) begin
      clear_ctrl = 1'b1;
    end else begin
      case (state_q)
        EMPTY: load_in = in_fire;
        ONE: begin
          load_in    = in_fire & out_fire;
          load_skid  = in_fire & ~out_fire;
          clear_ctrl = ~in_fire & out_fire;
        end
        TWO:     load_from_skid = out_fire;
        default: clear_ctrl = 1'b1;
      endcase
    end
  end

  // Ready and valid come straight from the next state, so both leave on flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      IN_READY  <= 1'b1;
      OUT_DATA  <= '0;
      OUT_CTRL  <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      OUT_VALID <= (state_d != EMPTY);
      IN_READY  <= (state_d != TWO);
      if (load_in) begin
        OUT_DATA <= IN_DATA;
        OUT_CTRL <= IN_CTRL;
      end else if (load_from_skid) begin
        OUT_DATA <= skid_data;
        OUT_CTRL <= skid_ctrl;
      end else if (clear_ctrl) begin
        OUT_CTRL <= '0;
      end
      if (load_skid) begin
        skid_data <= IN_DATA;
        skid_ctrl <= IN_CTRL;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk       (CLK),
    .rst       (RST),
    .stall     (OUT_VALID & ~OUT_READY),
    .flush     (FLUSH & (state_q != EMPTY)),
    .stall_cnt (STALL_CNT),
    .flush_cnt (FLUSH_CNT)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (stats checks when PIPE_STAGE_STATS_EN is defined).
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 69;
  localparam int unsigned CTRL_W = 7;

  logic              CLK = 1'b0;
  logic              RST;
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic [CTRL_W-1:0] IN_CTRL;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [CTRL_W-1:0] OUT_CTRL;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] STALL_CNT;
  logic [15:0] FLUSH_CNT;
  logic        in_ready2, out_valid2;
  logic [DATA_W-1:0] out_data2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [1:0]  stall_cnt2;
  logic [1:0]  flush_cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL)
`ifdef PIPE_STAGE_STATS_EN
    , .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
  );

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_small (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready2), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(out_valid2), .OUT_READY(OUT_READY), .OUT_DATA(out_data2), .OUT_CTRL(out_ctrl2),
    .STALL_CNT(stall_cnt2), .FLUSH_CNT(flush_cnt2)
  );
`endif

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_DATA = '0; IN_CTRL = '0;
    #3;
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA} !== {1'b0, 1'b1, 7'h00, 69'h0}) begin
      $display("FAIL reset: valid=%b ready=%b ctrl=%h data=%h, want 0/1/00/0",
               OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA);
      failures++;
    end
    step();
    RST = 1'b0;
    step();
    checks++;
    if ({OUT_VALID, IN_READY} !== 2'b01) begin
      $display("FAIL reset_release: valid=%b ready=%b, want 0/1", OUT_VALID, IN_READY);
      failures++;
    end
  endtask

  task automatic test_streaming();
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IN_DATA   = 69'h1;
    IN_CTRL   = 7'h11;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if ({OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA} !== {1'b1, 1'b1, 7'(8'h10 + i), 69'(i)}) begin
        $display("FAIL stream[%0d]: valid=%b ready=%b ctrl=%h data=%h, want 1/1/%h/%h",
                 i, OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA, 7'(8'h10 + i), 69'(i));
        failures++;
      end
      if (i < 8) begin
        IN_DATA = 69'(i + 1);
        IN_CTRL = 7'(8'h11 + i);
      end else begin
        IN_VALID = 1'b0;
      end
    end
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL} !== {1'b0, 1'b1, 7'h00}) begin
      $display("FAIL stream_drain: valid=%b ready=%b ctrl=%h, want 0/1/00", OUT_VALID, IN_READY, OUT_CTRL);
      failures++;
    end
  endtask

  task automatic test_stall_fill();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    IN_DATA   = 69'h10;
    IN_CTRL   = 7'h11;
    step();
    IN_DATA = 69'h20;
    IN_CTRL = 7'h22;
    step();
    IN_VALID = 1'b0;
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA} !== {1'b1, 1'b0, 7'h11, 69'h10}) begin
      $display("FAIL stall_two: valid=%b ready=%b ctrl=%h data=%h, want 1/0/11/10",
               OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA);
      failures++;
    end
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_DATA} !== {1'b1, 1'b0, 69'h10}) begin
      $display("FAIL stall_hold: valid=%b ready=%b data=%h, want 1/0/10", OUT_VALID, IN_READY, OUT_DATA);
      failures++;
    end
    OUT_READY = 1'b1;
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA} !== {1'b1, 1'b1, 7'h22, 69'h20}) begin
      $display("FAIL stall_skid_out: valid=%b ready=%b ctrl=%h data=%h, want 1/1/22/20",
               OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA);
      failures++;
    end
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL} !== {1'b0, 1'b1, 7'h00}) begin
      $display("FAIL stall_drain: valid=%b ready=%b ctrl=%h, want 0/1/00", OUT_VALID, IN_READY, OUT_CTRL);
      failures++;
    end
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    IN_DATA   = 69'h40; IN_CTRL = 7'h44;
    step();
    IN_DATA   = 69'h50; IN_CTRL = 7'h55;
    step();
    // In TWO: flush while upstream keeps presenting a new entry
    FLUSH   = 1'b1;
    IN_DATA = 69'h60; IN_CTRL = 7'h66;
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL} !== {1'b0, 1'b1, 7'h00}) begin
      $display("FAIL flush_two: valid=%b ready=%b ctrl=%h, want 0/1/00", OUT_VALID, IN_READY, OUT_CTRL);
      failures++;
    end
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
    checks++;
    if ({OUT_VALID, OUT_CTRL} !== {1'b0, 7'h00}) begin
      $display("FAIL flush_two_after: valid=%b ctrl=%h, want 0/00", OUT_VALID, OUT_CTRL);
      failures++;
    end
    // In ONE: flush drops an input that really fires in the same cycle
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_DATA = 69'h70; IN_CTRL = 7'h77;
    step();
    checks++;
    if ({OUT_VALID, OUT_DATA} !== {1'b1, 69'h70}) begin
      $display("FAIL flush_one_load: valid=%b data=%h, want 1/70", OUT_VALID, OUT_DATA);
      failures++;
    end
    FLUSH = 1'b1; IN_DATA = 69'h80; IN_CTRL = 7'h08;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL} !== {1'b0, 1'b1, 7'h00}) begin
      $display("FAIL flush_one: valid=%b ready=%b ctrl=%h, want 0/1/00", OUT_VALID, IN_READY, OUT_CTRL);
      failures++;
    end
    step();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      $display("FAIL flush_one_dropped: valid=%b, want 0", OUT_VALID);
      failures++;
    end
  endtask

  task automatic test_bubble();
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1; IN_DATA = 69'h99; IN_CTRL = 7'h7F;
    step();
    IN_VALID = 1'b0;
    checks++;
    if ({OUT_VALID, OUT_CTRL, OUT_DATA} !== {1'b1, 7'h7F, 69'h99}) begin
      $display("FAIL bubble_load: valid=%b ctrl=%h data=%h, want 1/7f/99", OUT_VALID, OUT_CTRL, OUT_DATA);
      failures++;
    end
    step();
    checks++;
    if ({OUT_VALID, OUT_CTRL} !== {1'b0, 7'h00}) begin
      $display("FAIL bubble_ctrl: valid=%b ctrl=%h, want 0/00", OUT_VALID, OUT_CTRL);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_DATA = 69'hA0; IN_CTRL = 7'h5A;
    step();
    IN_DATA = 69'hB0; IN_CTRL = 7'h3B;
    step();
    IN_VALID = 1'b0;
    checks++;
    if ({OUT_VALID, IN_READY} !== 2'b10) begin
      $display("FAIL areset_fill: valid=%b ready=%b, want 1/0", OUT_VALID, IN_READY);
      failures++;
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA} !== {1'b0, 1'b1, 7'h00, 69'h0}) begin
      $display("FAIL areset_mid: valid=%b ready=%b ctrl=%h data=%h, want 0/1/00/0",
               OUT_VALID, IN_READY, OUT_CTRL, OUT_DATA);
      failures++;
    end
    #2 RST = 1'b0;
    OUT_READY = 1'b1;
    step();
    checks++;
    if ({OUT_VALID, IN_READY, OUT_CTRL} !== {1'b0, 1'b1, 7'h00}) begin
      $display("FAIL areset_after: valid=%b ready=%b ctrl=%h, want 0/1/00", OUT_VALID, IN_READY, OUT_CTRL);
      failures++;
    end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1; IN_DATA = 69'hC0; IN_CTRL = 7'h0C;
    step();
    IN_VALID = 1'b0;
    repeat (5) step();
    checks++;
    if ({STALL_CNT, stall_cnt2} !== {16'd5, 2'd3}) begin
      $display("FAIL stats_stall: cnt=%0d small=%0d, want 5/3", STALL_CNT, stall_cnt2);
      failures++;
    end
    FLUSH = 1'b1; OUT_READY = 1'b1;
    step();
    step();
    FLUSH = 1'b0;
    checks++;
    if ({FLUSH_CNT, STALL_CNT, flush_cnt2, stall_cnt2} !== {16'd1, 16'd5, 2'd1, 2'd3}) begin
      $display("FAIL stats_flush: flush=%0d stall=%0d small_flush=%0d small_stall=%0d, want 1/5/1/3",
               FLUSH_CNT, STALL_CNT, flush_cnt2, stall_cnt2);
      failures++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_bubble();
    test_async_reset();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
